// File: rtl/fill_pkg.sv
// Shared types and default geometry for the rectangle fill engine.
package fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef enum logic [1:0] {
    SOLID      = 2'd0,
    COL_STRIPE = 2'd1,
    ROW_STRIPE = 2'd2,
    CHECKER    = 2'd3
  } fill_mode_t;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_XW       = 8;
  localparam int DEF_YW       = 7;
  localparam int DEF_CW       = 3;

endpackage

// File: rtl/fillscreen_rect_if.sv
// Request/response bundle between the control FSM and the fill engine, plus the VGA pixel port.
// Handshake: start is a level request; done stays high until start drops, then the block returns to IDLE.
interface fillscreen_rect_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) ();
  logic          start;
  logic [1:0]    mode;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [XW:0]   w;
  logic [YW:0]   h;
  logic [CW-1:0] colour;
  logic          done;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (
    output start, mode, x0, y0, w, h, colour,
    input  done, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  start, mode, x0, y0, w, h, colour,
    output done, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/scan_counter_2d.sv
// Column-major offset counters: dy runs fastest, dx steps when dy wraps at h-1.
module scan_counter_2d #(
  parameter int XW = 8,
  parameter int YW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [XW:0] w,
  input  logic [YW:0] h,
  output logic [XW:0] dx,
  output logic [YW:0] dy,
  output logic        last
);

  logic [XW:0] dx_q, dx_d;
  logic [YW:0] dy_q, dy_d;
  logic        dy_wrap;
  logic        dx_end;

  assign dy_wrap = (dy_q == h - (YW+1)'(1));
  assign dx_end  = (dx_q == w - (XW+1)'(1));

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = '0;
      dy_d = '0;
    end else if (en) begin
      if (dy_wrap) begin
        dy_d = '0;
        dx_d = dx_q + (XW+1)'(1);
      end else begin
        dy_d = dy_q + (YW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = dy_wrap && dx_end;

endmodule

// File: rtl/fillscreen_rect.sv
// Rectangle fill engine: one pixel per clock, column-major, four colour modes.
// Define FILL_CLIP_EN to clip the rectangle to the screen at latch time; otherwise coordinates wrap.
module fillscreen_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int XW       = DEF_XW,
  parameter int YW       = DEF_YW,
  parameter int CW       = DEF_CW
) (
  input  logic         clk,
  input  logic         rst,
  fillscreen_rect_if.slave bus,
  output fill_state_t  state_o
);

`ifdef FILL_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  fill_state_t   state_q;
  fill_mode_t    mode_q;
  logic [XW-1:0] x0_q;
  logic [YW-1:0] y0_q;
  logic [XW:0]   w_q;
  logic [YW:0]   h_q;
  logic [CW-1:0] colour_q;
  logic          done_q;
  logic          plot_q;

  logic [XW:0]   dx;
  logic [YW:0]   dy;
  logic          last;

  // Room left on screen from the requested origin; zero once the origin is off-screen.
  logic [XW:0]   x_room;
  logic [YW:0]   y_room;
  logic [XW:0]   w_clip;
  logic [YW:0]   h_clip;
  logic [XW:0]   w_eff;
  logic [YW:0]   h_eff;

  assign x_room = ({1'b0, bus.x0} >= (XW+1)'(SCREEN_W)) ? '0
                : (XW+1)'(SCREEN_W) - {1'b0, bus.x0};
  assign y_room = ({1'b0, bus.y0} >= (YW+1)'(SCREEN_H)) ? '0
                : (YW+1)'(SCREEN_H) - {1'b0, bus.y0};
  assign w_clip = (bus.w < x_room) ? bus.w : x_room;
  assign h_clip = (bus.h < y_room) ? bus.h : y_room;
  assign w_eff  = CLIP_EN ? w_clip : bus.w;
  assign h_eff  = CLIP_EN ? h_clip : bus.h;

  scan_counter_2d #(.XW(XW), .YW(YW)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .clear (state_q == IDLE),
    .en    (state_q == FILL),
    .w     (w_q),
    .h     (h_q),
    .dx    (dx),
    .dy    (dy),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= SOLID;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
      done_q   <= 1'b0;
      plot_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= fill_mode_t'(bus.mode);
            x0_q     <= bus.x0;
            y0_q     <= bus.y0;
            w_q      <= w_eff;
            h_q      <= h_eff;
            colour_q <= bus.colour;
            if ((w_eff == '0) || (h_eff == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= FILL;
              plot_q  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (last) begin
            state_q <= DONE;
            plot_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (!bus.start) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          plot_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [CW-1:0] pcol;

  assign px = x0_q + dx[XW-1:0];
  assign py = y0_q + dy[YW-1:0];

  always_comb begin
    pcol = colour_q;
    case (mode_q)
      SOLID:      pcol = colour_q;
      COL_STRIPE: pcol = px[CW-1:0];
      ROW_STRIPE: pcol = py[CW-1:0];
      CHECKER:    pcol = colour_q ^ {CW{px[0] ^ py[0]}};
      default:    pcol = colour_q;
    endcase
  end

  assign bus.vga_x      = px;
  assign bus.vga_y      = py;
  assign bus.vga_colour = pcol;
  assign bus.vga_plot   = plot_q;
  assign bus.done       = done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fillscreen_rect.sv
// Directed bench for fillscreen_rect: vector table of rectangles plus reset/abort sequences.
`timescale 1ns/1ps
module tb_fillscreen_rect;
  import fill_pkg::*;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 3;
  localparam int PW = XW + YW + CW;

  logic clk;
  logic rst;
  fill_state_t state;

  fillscreen_rect_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  fillscreen_rect #(.SCREEN_W(160), .SCREEN_H(120), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] pix(input int x, input int y, input int c);
    logic [XW-1:0] xv;
    logic [YW-1:0] yv;
    logic [CW-1:0] cv;
    xv = XW'(x);
    yv = YW'(y);
    cv = CW'(c);
    return {xv, yv, cv};
  endfunction

  typedef struct {
    int x0;
    int y0;
    int w;
    int h;
    int mode;
    int colour;
    int exp_n;
    int exp_lat;
    logic [PW-1:0] exp_first;
    logic [PW-1:0] exp_last;
  } vec_t;

  // Reference model: column-major walk of the requested rectangle.
  task automatic build_expected(input vec_t v);
    int we, he, x, y, c;
    we = v.w;
    he = v.h;
`ifdef FILL_CLIP_EN
    if (v.x0 >= 160) we = 0; else if (we > 160 - v.x0) we = 160 - v.x0;
    if (v.y0 >= 120) he = 0; else if (he > 120 - v.y0) he = 120 - v.y0;
`endif
    exp_q.delete();
    for (int dx = 0; dx < we; dx++) begin
      for (int dy = 0; dy < he; dy++) begin
        x = (v.x0 + dx) % 256;
        y = (v.y0 + dy) % 128;
        case (v.mode)
          0: c = v.colour;
          1: c = x % 8;
          2: c = y % 8;
          default: c = v.colour ^ ((((x ^ y) & 1) != 0) ? 7 : 0);
        endcase
        exp_q.push_back(pix(x, y, c));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_req(input vec_t v);
    bus.x0     = XW'(v.x0);
    bus.y0     = YW'(v.y0);
    bus.w      = (XW+1)'(v.w);
    bus.h      = (YW+1)'(v.h);
    bus.mode   = 2'(v.mode);
    bus.colour = CW'(v.colour);
    bus.start  = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus.x0     = XW'($urandom_range(0, 255));
    bus.y0     = YW'($urandom_range(0, 127));
    bus.w      = (XW+1)'($urandom_range(1, 511));
    bus.h      = (YW+1)'($urandom_range(1, 255));
    bus.mode   = 2'($urandom_range(0, 3));
    bus.colour = CW'($urandom_range(0, 7));
  endtask

  task automatic run_fill(input vec_t v, input string tag);
    int n, done_cyc;
    logic [PW-1:0] got, first, last, e;
    n = 0;
    done_cyc = 0;
    first = '0;
    last = '0;
    @(negedge clk);
    build_expected(v);
    drive_req(v);
    @(posedge clk);
    #1 scramble_inputs();
    for (int cyc = 1; cyc <= v.exp_n + 20; cyc++) begin
      @(negedge clk);
      if (bus.vga_plot) begin
        got = {bus.vga_x, bus.vga_y, bus.vga_colour};
        if (n == 0) first = got;
        last = got;
        n++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (got !== e) check({tag, "_pixel"}, 32'(got), 32'(e));
          else begin
            n_checks++;
            n_pass++;
          end
        end else begin
          check({tag, "_extra_plot"}, n, v.exp_n);
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        check({tag, "_plot_with_done"}, 32'(bus.vga_plot), 32'd0);
        break;
      end
    end
    check({tag, "_done_latency"}, done_cyc, v.exp_lat);
    check({tag, "_plot_count"}, n, v.exp_n);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    if (v.exp_n > 0) begin
      check({tag, "_first_pixel"}, 32'(first), 32'(v.exp_first));
      check({tag, "_last_pixel"}, 32'(last), 32'(v.exp_last));
    end
    // Holding start keeps the block parked in DONE with no new plots.
    repeat (2) begin
      @(negedge clk);
      check({tag, "_hold_done"}, 32'(bus.done), 32'd1);
      check({tag, "_hold_state"}, 32'(state), 32'(DONE));
      check({tag, "_hold_plot"}, 32'(bus.vga_plot), 32'd0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_back_idle"}, 32'(state), 32'(IDLE));
    check({tag, "_done_low"}, 32'(bus.done), 32'd0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 0, 160, 120, 1, 2, 19200, 19201, pix(0, 0, 0), pix(159, 119, 7)};
    vecs[1] = '{10, 5, 3, 2, 0, 5, 6, 7, pix(10, 5, 5), pix(12, 6, 5)};
    vecs[2] = '{4, 4, 0, 7, 0, 5, 0, 1, '0, '0};
    vecs[3] = '{0, 0, 2, 2, 3, 3, 4, 5, pix(0, 0, 3), pix(1, 1, 3)};
    vecs[4] = '{3, 6, 2, 3, 2, 0, 6, 7, pix(3, 6, 6), pix(4, 8, 0)};
    vecs[5] = '{9, 9, 5, 0, 1, 1, 0, 1, '0, '0};
    vecs[6] = '{7, 7, 1, 1, 3, 6, 1, 2, pix(7, 7, 6), pix(7, 7, 6)};
`ifdef FILL_CLIP_EN
    vecs[7] = '{158, 0, 10, 1, 0, 1, 2, 3, pix(158, 0, 1), pix(159, 0, 1)};
    vecs[8] = '{200, 0, 4, 4, 0, 1, 0, 1, '0, '0};
`else
    vecs[7] = '{254, 0, 3, 1, 1, 0, 3, 4, pix(254, 0, 6), pix(0, 0, 0)};
    vecs[8] = '{0, 126, 1, 3, 2, 0, 3, 4, pix(0, 126, 6), pix(0, 0, 0)};
`endif

    rst = 1'b1;
    bus.start = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.w = '0;
    bus.h = '0;
    bus.mode = '0;
    bus.colour = '0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_plot", 32'(bus.vga_plot), 32'd0);
    check("rst_xy", 32'({bus.vga_x, bus.vga_y}), 32'd0);
    check("rst_colour", 32'(bus.vga_colour), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_fill(vecs[i], $sformatf("vec%0d", i));

    // Abort a fill with reset after 50 plots, then refill from the origin.
    begin
      vec_t va;
      int plots;
      va = '{20, 10, 30, 30, 0, 4, 900, 901, pix(20, 10, 4), pix(49, 39, 4)};
      plots = 0;
      @(negedge clk);
      drive_req(va);
      @(posedge clk);
      for (int cyc = 0; cyc < 60; cyc++) begin
        @(negedge clk);
        if (bus.vga_plot) plots++;
        if (plots == 50) break;
      end
      check("abort_plots_before", plots, 50);
      rst = 1'b1;
      @(negedge clk);
      check("abort_plot", 32'(bus.vga_plot), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_state", 32'(state), 32'(IDLE));
      @(negedge clk);
      check("reset_wins_state", 32'(state), 32'(IDLE));
      check("reset_wins_plot", 32'(bus.vga_plot), 32'd0);
      rst = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      check("abort_idle_after", 32'(state), 32'(IDLE));
      run_fill(va, "refill");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fillscreen_rect.md
# fillscreen_rect

Parametrised successor to the lab's full-screen fill engine. Paints an arbitrary rectangle of the VGA adapter framebuffer, one pixel per clock, in column-major order, using one of four colour modes. It sits between the top-level control FSM and the VGA adapter's `x/y/colour/plot` port, and uses the same start/done handshake as the existing fill and draw blocks.

## Interface
Parameters:
- `SCREEN_W`, default 160: framebuffer width in pixels.
- `SCREEN_H`, default 120: framebuffer height in pixels.
- `XW`, default 8: x coordinate width.
- `YW`, default 7: y coordinate width.
- `CW`, default 3: colour width.

Ports:
- `clk`  in  1: single clock; all state is updated on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a fill; level-sensitive.
- `mode`  in  2: colour mode. 0 SOLID, 1 COL_STRIPE, 2 ROW_STRIPE, 3 CHECKER.
- `x0`  in  XW: rectangle left edge.
- `y0`  in  YW: rectangle top edge.
- `w`  in  XW+1: rectangle width; 0 is legal.
- `h`  in  YW+1: rectangle height; 0 is legal.
- `colour`  in  CW: base colour.
- `done`  out  1: fill complete.
- `vga_x`  out  XW: pixel x.
- `vga_y`  out  YW: pixel y.
- `vga_colour`  out  CW: pixel colour.
- `vga_plot`  out  1: pixel write strobe.

## Operation
- States: IDLE, FILL, DONE.
- IDLE:
  - A rising edge with `start`=1 latches `mode`, `x0`, `y0`, `w`, `h` and `colour`.
  - It clears the offset counters `dx`=`dy`=0.
  - Next state is FILL, or DONE if the effective `w` or `h` is 0.
- FILL:
  - Each cycle `vga_plot`=1, `vga_x`=`x0`+`dx` and `vga_y`=`y0`+`dy`, truncated to XW and YW bits.
  - `dy` increments fastest. At `dy`=h-1, `dy` returns to 0 and `dx` increments.
  - At `dx`=w-1 and `dy`=h-1, the next state is DONE.
- Colour by mode:
  - SOLID: `colour`.
  - COL_STRIPE: `vga_x`[CW-1:0].
  - ROW_STRIPE: `vga_y`[CW-1:0].
  - CHECKER: `colour` XOR {CW{`vga_x`[0]^`vga_y`[0]}}.
- DONE:
  - `done`=1 and `vga_plot`=0.
  - The block stays in DONE while `start`=1 and returns to IDLE the cycle after `start`=0.
- Inputs other than `start` are ignored outside IDLE. Changing them mid-fill has no effect.

## Timing
- Reset values: state IDLE; `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `dx`=`dy`=0.
- Start-to-first-pixel latency: 1 cycle. `vga_*` are combinational from the registered state and counters.
- Exactly w·h consecutive `vga_plot` cycles, with no bubbles.
- `done` rises 1 cycle after the last plot, i.e. w·h+1 cycles after the accepting edge. An empty rectangle gives `done` after 1 cycle with zero plots.
- `rst` during FILL aborts the fill. The next cycle is IDLE with `vga_plot`=0 and no further pixels.
- If `start` is held high continuously, only one fill occurs. A new fill requires `start` to drop and the block to pass through IDLE.
- If `rst` and `start` are both high, reset wins.

## Configuration
- `FILL_CLIP_EN` defined:
  - At latch, effective w = min(w, SCREEN_W−x0) and effective h = min(h, SCREEN_H−y0).
  - If x0≥SCREEN_W or y0≥SCREEN_H, the effective size is 0.
  - Off-screen coordinates are never emitted.
- `FILL_CLIP_EN` undefined:
  - w and h are used as given.
  - Coordinates wrap modulo 2^XW and 2^YW. Off-screen pixels are emitted and are the caller's responsibility.

## Structure
- Package `fill_pkg`:
  - `fill_state_t` enum (IDLE, FILL, DONE).
  - `fill_mode_t` enum (SOLID, COL_STRIPE, ROW_STRIPE, CHECKER).
  - Default screen constants.
- Sub-module `scan_counter_2d`:
  - Holds the `dx`/`dy` counters.
  - Ports: `clk`, `rst`, `clear`, `en`, `w`, `h`, `dx`, `dy`, `last`.
  - `last` is asserted when `dx`=w-1 and `dy`=h-1.
- Top level: FSM, latch registers, clipping and colour mux.

## Test plan
- Full screen: x0=0, y0=0, w=160, h=120, mode COL_STRIPE.
  - Expect 19200 plots; first pixel (0,0) colour 0; last pixel (159,119) colour 7.
  - Expect `done`=1 on cycle 19201 after acceptance; state DONE until `start`=0.
- Small rectangle: x0=10, y0=5, w=3, h=2, SOLID colour 5.
  - Expect plot sequence (10,5) (10,6) (11,5) (11,6) (12,5) (12,6), all colour 5.
  - Expect `done` on the 7th cycle.
- w=0, h=7: expect zero plots and `done` 1 cycle after acceptance.
- CHECKER, colour 3, 2×2 at (0,0): expect colours 3, 4, 4, 3.
- `FILL_CLIP_EN` defined, x0=158, w=10, h=1: expect exactly 2 plots, at x=158 and x=159.
- `rst` asserted after 50 FILL cycles: expect next cycle `vga_plot`=0, `done`=0, state IDLE.
  - After `start` is re-asserted, expect a fresh fill that begins at (x0,y0).
